// File: rtl/udp_tx_arbiter_if.sv
// Byte-wide AXI-Stream link used by the UDP TX payload arbiter.
// The master drives data/valid/last/user and the slave returns ready.
interface udp_tx_arbiter_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Two-requester, packet-granular round-robin arbiter feeding the UDP TX payload stream.
// Packets longer than MAX_LEN are cut (tlast+tuser forced) and their tail is dropped.
module udp_tx_arbiter #(
    parameter int unsigned MAX_LEN = 1472
) (
    input  logic              clk,
    input  logic              rst,
    udp_tx_arbiter_if.slave   s0_axis,
    udp_tx_arbiter_if.slave   s1_axis,
    udp_tx_arbiter_if.master  m_axis,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [15:0]       pkt_cnt0,
    output logic [15:0]       pkt_cnt1,
    output logic [15:0]       trunc_cnt
);

    localparam logic [15:0] LastIdx = 16'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPass0,
        StPass1,
        StDrop0,
        StDrop1
    } state_e;

    state_e      state_q, state_d;
    logic        last_srv_q, last_srv_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [15:0] pkt_cnt1_q, pkt_cnt1_d;
    logic [15:0] trunc_cnt_q, trunc_cnt_d;

    logic       sel1;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_last;
    logic       src_user;
    logic       src_ready;
    logic       at_max;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_user;
    logic [1:0] grant_c;
    logic       busy_c;

    always_comb begin
        state_d     = state_q;
        last_srv_d  = last_srv_q;
        byte_cnt_d  = byte_cnt_q;
        pkt_cnt0_d  = pkt_cnt0_q;
        pkt_cnt1_d  = pkt_cnt1_q;
        trunc_cnt_d = trunc_cnt_q;
        src_ready   = 1'b0;
        m_data      = 8'h00;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_user      = 1'b0;
        grant_c     = 2'b00;
        busy_c      = 1'b0;

        sel1      = (state_q == StPass1) || (state_q == StDrop1);
        src_data  = sel1 ? s1_axis.tdata  : s0_axis.tdata;
        src_valid = sel1 ? s1_axis.tvalid : s0_axis.tvalid;
        src_last  = sel1 ? s1_axis.tlast  : s0_axis.tlast;
        src_user  = sel1 ? s1_axis.tuser  : s0_axis.tuser;
        // The current beat is the MAX_LEN-th byte of the packet.
        at_max    = (byte_cnt_q == LastIdx);

        unique case (state_q)
            StIdle: begin
                // last_srv_q == 1 means port 1 was served last, so port 0 wins a tie.
                if (s0_axis.tvalid && (!s1_axis.tvalid || last_srv_q)) begin
                    state_d    = StPass0;
                    last_srv_d = 1'b0;
                    byte_cnt_d = 16'd0;
                end else if (s1_axis.tvalid) begin
                    state_d    = StPass1;
                    last_srv_d = 1'b1;
                    byte_cnt_d = 16'd0;
                end
            end
            StPass0, StPass1: begin
                grant_c   = sel1 ? 2'b10 : 2'b01;
                busy_c    = 1'b1;
                m_data    = src_data;
                m_valid   = src_valid;
                m_last    = at_max | src_last;
                m_user    = (at_max & ~src_last) | src_user;
                src_ready = m_axis.tready;
                if (src_valid && m_axis.tready) begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (at_max || src_last) begin
                        if (sel1) begin
                            pkt_cnt1_d = pkt_cnt1_q + 16'd1;
                        end else begin
                            pkt_cnt0_d = pkt_cnt0_q + 16'd1;
                        end
                        if (at_max && !src_last) begin
                            trunc_cnt_d = trunc_cnt_q + 16'd1;
                            if (sel1) begin
                                state_d = StDrop1;
                            end else begin
                                state_d = StDrop0;
                            end
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StDrop0, StDrop1: begin
                grant_c   = sel1 ? 2'b10 : 2'b01;
                busy_c    = 1'b1;
                src_ready = 1'b1;
                if (src_valid && src_last) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Reset silences every output in the same cycle so no handshake can complete.
        if (rst) begin
            src_ready = 1'b0;
            m_data    = 8'h00;
            m_valid   = 1'b0;
            m_last    = 1'b0;
            m_user    = 1'b0;
            grant_c   = 2'b00;
            busy_c    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_srv_q  <= 1'b1;
            byte_cnt_q  <= 16'd0;
            pkt_cnt0_q  <= 16'd0;
            pkt_cnt1_q  <= 16'd0;
            trunc_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            last_srv_q  <= last_srv_d;
            byte_cnt_q  <= byte_cnt_d;
            pkt_cnt0_q  <= pkt_cnt0_d;
            pkt_cnt1_q  <= pkt_cnt1_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign s0_axis.tready = src_ready & ~sel1;
    assign s1_axis.tready = src_ready & sel1;
    assign m_axis.tdata   = m_data;
    assign m_axis.tvalid  = m_valid;
    assign m_axis.tlast   = m_last;
    assign m_axis.tuser   = m_user;
    assign grant          = grant_c;
    assign busy           = busy_c;
    assign pkt_cnt0       = pkt_cnt0_q;
    assign pkt_cnt1       = pkt_cnt1_q;
    assign trunc_cnt      = trunc_cnt_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: a packet-level round-robin model predicts the
// output beat stream, and a monitor checks every m_axis handshake against it.
module tb_udp_tx_arbiter;

    localparam int unsigned MaxLen = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;
    logic [15:0] trunc_cnt;

    udp_tx_arbiter_if s0_if ();
    udp_tx_arbiter_if s1_if ();
    udp_tx_arbiter_if m_if ();

    always #4 clk = ~clk;

    udp_tx_arbiter #(
        .MAX_LEN (MaxLen)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s0_axis   (s0_if),
        .s1_axis   (s1_if),
        .m_axis    (m_if),
        .grant     (grant),
        .busy      (busy),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
        .trunc_cnt (trunc_cnt)
    );

    typedef struct packed {
        logic [7:0]   len;
        logic [127:0] data;
        logic [15:0]  user;
    } pkt_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic [1:0] grant;
        logic       first;
        logic       to_idle;
    } beat_t;

    pkt_t  p0[$];
    pkt_t  p1[$];
    beat_t exp_q[$];
    bit    rdy_pat[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_pkt0, exp_pkt1, exp_trunc;
    int rdy_mode = 0;
    bit check_gap = 1'b0;
    bit gaps_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {m_if.tvalid, m_if.tlast, m_if.tuser, s0_if.tready, s1_if.tready,
                     grant, busy, pkt_cnt0, pkt_cnt1, trunc_cnt}, 64'd0);
    endtask

    task automatic set_src(input int src, input logic v, input logic [7:0] d,
                           input logic l, input logic u);
        if (src == 0) begin
            s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l; s0_if.tuser = u;
        end else begin
            s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l; s1_if.tuser = u;
        end
    endtask

    function automatic logic src_ready(input int src);
        return (src == 0) ? s0_if.tready : s1_if.tready;
    endfunction

    // Returns just after the edge on which the presented beat was accepted.
    task automatic wait_hs(input int src);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (src_ready(src)) done = 1'b1;
        end
        if (done) begin
            @(posedge clk);
            #1;
        end else begin
            check($sformatf("hs_timeout_s%0d", src), 64'd0, 64'd1);
        end
    endtask

    function automatic pkt_t mk_pkt(input int len);
        pkt_t p;
        p.len = 8'(len);
        for (int b = 0; b < 16; b++) begin
            p.data[b*8 +: 8] = 8'($urandom);
            p.user[b] = ($urandom_range(7) == 0);
        end
        return p;
    endfunction

    // Packet-level model: round robin over pending packets, truncation at MaxLen.
    function automatic void build_expected();
        int    i0 = 0;
        int    i1 = 0;
        int    last = 1;
        int    pick;
        int    n_out;
        pkt_t  p;
        beat_t e;
        exp_pkt0 = 0; exp_pkt1 = 0; exp_trunc = 0;
        while (i0 < p0.size() || i1 < p1.size()) begin
            if (i0 < p0.size() && i1 < p1.size()) pick = 1 - last;
            else pick = (i0 < p0.size()) ? 0 : 1;
            if (pick == 0) begin p = p0[i0]; i0++; exp_pkt0++; end
            else begin p = p1[i1]; i1++; exp_pkt1++; end
            last = pick;
            n_out = (int'(p.len) > MaxLen) ? MaxLen : int'(p.len);
            if (int'(p.len) > MaxLen) exp_trunc++;
            for (int b = 0; b < n_out; b++) begin
                e.data    = p.data[b*8 +: 8];
                e.last    = (b == n_out - 1);
                e.user    = (int'(p.len) > MaxLen && b == n_out - 1) ? 1'b1 : p.user[b];
                e.grant   = (pick == 1) ? 2'b10 : 2'b01;
                e.first   = (b == 0);
                e.to_idle = e.last && (int'(p.len) <= MaxLen);
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic drive_pkts(input int src);
        int   n;
        pkt_t p;
        n = (src == 0) ? p0.size() : p1.size();
        for (int k = 0; k < n; k++) begin
            p = (src == 0) ? p0[k] : p1[k];
            for (int b = 0; b < int'(p.len); b++) begin
                if (gaps_en && b != 0 && $urandom_range(3) == 0) begin
                    set_src(src, 1'b0, 8'h00, 1'b0, 1'b0);
                    repeat ($urandom_range(1, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                set_src(src, 1'b1, p.data[b*8 +: 8], b == int'(p.len) - 1, p.user[b]);
                wait_hs(src);
            end
        end
        set_src(src, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("after_reset");
        p0.delete();
        p1.delete();
        exp_q.delete();
    endtask

    task automatic run_phase(input string name);
        bit done = 1'b0;
        build_expected();
        fork
            drive_pkts(0);
            drive_pkts(1);
        join
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy"}, {62'd0, grant, busy}, 64'd0);
        check({name, "_pkt_cnt0"}, 64'(pkt_cnt0), 64'(exp_pkt0));
        check({name, "_pkt_cnt1"}, 64'(pkt_cnt1), 64'(exp_pkt1));
        check({name, "_trunc_cnt"}, 64'(trunc_cnt), 64'(exp_trunc));
    endtask

    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_if.tready = 1'b1;
                1: m_if.tready = ($urandom_range(9) < 7);
                default: m_if.tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
            endcase
        end
    end

    // Monitor: compares every accepted output beat against the scoreboard head.
    initial begin
        bit    idle_chk;
        bit    have_end;
        int    end_cyc;
        beat_t e;
        idle_chk = 1'b0;
        have_end = 1'b0;
        end_cyc  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                idle_chk = 1'b0;
                have_end = 1'b0;
            end else begin
                if (idle_chk) begin
                    check("idle_between_pkts", {61'd0, grant, busy}, 64'd0);
                    idle_chk = 1'b0;
                end
                if (m_if.tvalid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q[0];
                        check("tready_mirror", {62'd0, s0_if.tready, s1_if.tready},
                              (e.grant == 2'b01) ? {62'd0, m_if.tready, 1'b0}
                                                 : {62'd0, 1'b0, m_if.tready});
                        if (m_if.tready) begin
                            void'(exp_q.pop_front());
                            check("beat", {52'd0, m_if.tdata, m_if.tlast, m_if.tuser, grant},
                                  {52'd0, e.data, e.last, e.user, e.grant});
                            if (e.first && check_gap && have_end)
                                check("pkt_gap_cycles", 64'(cyc - end_cyc), 64'd2);
                            if (e.to_idle) begin
                                idle_chk = 1'b1;
                                have_end = 1'b1;
                                end_cyc  = cyc;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t  p;
        beat_t e;
        rst = 1'b1;
        set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Single 4-byte packet on s0.
        do_reset();
        p = mk_pkt(4);
        p.data[31:0] = 32'h4433_2211;
        p.user = '0;
        p0.push_back(p);
        run_phase("single");

        // Simultaneous requests, two 3-byte packets per port.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            p0.push_back(mk_pkt(3));
            p1.push_back(mk_pkt(3));
        end
        check_gap = 1'b1;
        run_phase("rr");
        check_gap = 1'b0;

        // Over-length packet then an exactly MaxLen packet on s1.
        do_reset();
        p = mk_pkt(12);
        p.user = '0;
        p1.push_back(p);
        p = mk_pkt(8);
        p.user = '0;
        p1.push_back(p);
        run_phase("trunc");

        // Backpressure pattern mid-packet.
        do_reset();
        p0.push_back(mk_pkt(6));
        rdy_mode = 2;
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_phase("bp");
        rdy_mode = 0;

        // Reset in the middle of a 5-byte packet.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            e.data = 8'(8'hA0 + b); e.last = 1'b0; e.user = 1'b0;
            e.grant = 2'b01; e.first = (b == 0); e.to_idle = 1'b0;
            exp_q.push_back(e);
            set_src(0, 1'b1, 8'(8'hA0 + b), 1'b0, 1'b0);
            wait_hs(0);
        end
        set_src(0, 1'b1, 8'hA2, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_mid_pkt");
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_zero("post_rst_mid_pkt");
        check("rst_mid_pkt_consumed", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_no_flush", {62'd0, m_if.tvalid, busy}, 64'd0);

        // Randomized traffic with source gaps and random backpressure.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int k = 0; k < 10; k++) begin
                p0.push_back(mk_pkt($urandom_range(1, 12)));
                p1.push_back(mk_pkt($urandom_range(1, 12)));
            end
            if (r == 2) void'(p1.pop_back());
            rdy_mode = 1;
            gaps_en = 1'b1;
            run_phase($sformatf("rand%0d", r));
            rdy_mode = 0;
            gaps_en = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
